// File: rtl/multicycle_control.sv
// Multi-cycle RV32I main control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with
// handshake or fixed-latency memory waits, branch resolution and an illegal-opcode trap.
module multicycle_control #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int MEM_LAT       = 1,
  parameter int TRAP_EN       = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [2:0] compare,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       PCWrite,
  output logic       InstructionRead,
  output logic       Regwrite,
  output logic       Memorywrite,
  output logic       Memoryread,
  output logic       Mux_ALU_rs2,
  output logic       Mux_ALU_pc,
  output logic       Branch,
  output logic [1:0] wb_sel,
  output logic       illegal,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q;
  logic [6:0] op_q;
  logic [2:0] f3_q;
  logic       illegal_q;

  function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
      OP_BR:   return (f3 != 3'd2) && (f3 != 3'd3);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic [2:0] cmp);
    case (f3)
      3'd0:    return cmp[0];
      3'd1:    return ~cmp[0];
      3'd4:    return cmp[1];
      3'd5:    return ~cmp[1];
      3'd6:    return cmp[2];
      3'd7:    return ~cmp[2];
      default: return 1'b0;
    endcase
  endfunction

  logic lat_done, fetch_done, mem_done, dec_legal;
  logic is_load, is_store, is_br, is_jump;

  assign lat_done   = (cnt_q == LAT_LAST);
  assign fetch_done = (MEM_HANDSHAKE != 0) ? imem_ready : lat_done;
  assign mem_done   = (MEM_HANDSHAKE != 0) ? dmem_ready : lat_done;
  assign dec_legal  = is_legal(opcode, func3);
  assign is_load    = (op_q == OP_LOAD);
  assign is_store   = (op_q == OP_STORE);
  assign is_br      = (op_q == OP_BR);
  assign is_jump    = (op_q == OP_JAL) || (op_q == OP_JALR);

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (fetch_done) state_d = DECODE;
      DECODE: begin
        if (dec_legal)         state_d = EXEC;
        else if (TRAP_EN != 0) state_d = TRAP;
        else                   state_d = FETCH;
      end
      EXEC: begin
        if (is_br)                    state_d = FETCH;
        else if (is_load || is_store) state_d = MEM;
        else                          state_d = WB;
      end
      MEM:     if (mem_done) state_d = is_store ? FETCH : WB;
      WB:      state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  // The wait counter restarts on every state change so FETCH and MEM each get a full MEM_LAT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      cnt_q     <= '0;
      op_q      <= '0;
      f3_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? 4'd0 : cnt_q + 4'd1;
      if (state_q == DECODE) begin
        op_q <= opcode;
        f3_q <= func3;
      end
      if (state_d == TRAP) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    PCWrite         = 1'b0;
    InstructionRead = 1'b0;
    Regwrite        = 1'b0;
    Memorywrite     = 1'b0;
    Memoryread      = 1'b0;
    Mux_ALU_rs2     = 1'b0;
    Mux_ALU_pc      = 1'b0;
    Branch          = 1'b0;
    wb_sel          = 2'd0;
    case (state_q)
      FETCH:  InstructionRead = 1'b1;
      DECODE: PCWrite = !dec_legal && (TRAP_EN == 0);
      EXEC: begin
        Mux_ALU_rs2 = (op_q == OP_R);
        Mux_ALU_pc  = (op_q == OP_JAL) || (op_q == OP_AUIPC);
        if (is_br) begin
          PCWrite = 1'b1;
          Branch  = br_taken(f3_q, compare);
        end
      end
      MEM: begin
        Memoryread  = is_load;
        Memorywrite = is_store;
        PCWrite     = is_store && mem_done;
      end
      WB: begin
        Regwrite = 1'b1;
        PCWrite  = 1'b1;
        Branch   = is_jump;
        if (is_load)              wb_sel = 2'd1;
        else if (is_jump)         wb_sel = 2'd2;
        else if (op_q == OP_LUI)  wb_sel = 2'd3;
        else                      wb_sel = 2'd0;
      end
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a per-instruction expected-trace model drives inputs and
// checks every cycle on a handshake/trap instance and a fixed-latency/no-trap instance.
module tb_multicycle_control;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3, cmp;
    logic       ir, dr;
    logic [2:0] st;
    logic       pcw, ird, rw, mw, mr, rs2, apc, br, ill;
    logic [1:0] wb;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] func3 = '0, compare = '0;
  logic imem_ready = 1'b0, dmem_ready = 1'b0;

  logic pcw_a, ird_a, rw_a, mw_a, mr_a, rs2_a, apc_a, br_a, ill_a;
  logic pcw_b, ird_b, rw_b, mw_b, mr_b, rs2_b, apc_b, br_b, ill_b;
  logic [1:0] wb_a, wb_b;
  logic [2:0] st_a, st_b;
  logic [10:0] o_a, o_b;

  int checks = 0, failures = 0;
  bit sel = 1'b0;
  string cur = "reset";
  ent_t q[$];

  always #5 clk = ~clk;

  multicycle_control #(.MEM_HANDSHAKE(1), .MEM_LAT(1), .TRAP_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3), .compare(compare),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .PCWrite(pcw_a), .InstructionRead(ird_a), .Regwrite(rw_a), .Memorywrite(mw_a),
    .Memoryread(mr_a), .Mux_ALU_rs2(rs2_a), .Mux_ALU_pc(apc_a), .Branch(br_a),
    .wb_sel(wb_a), .illegal(ill_a), .state_o(st_a));

  multicycle_control #(.MEM_HANDSHAKE(0), .MEM_LAT(3), .TRAP_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3), .compare(compare),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .PCWrite(pcw_b), .InstructionRead(ird_b), .Regwrite(rw_b), .Memorywrite(mw_b),
    .Memoryread(mr_b), .Mux_ALU_rs2(rs2_b), .Mux_ALU_pc(apc_b), .Branch(br_b),
    .wb_sel(wb_b), .illegal(ill_b), .state_o(st_b));

  assign o_a = {pcw_a, ird_a, rw_a, mw_a, mr_a, rs2_a, apc_a, br_a, wb_a, ill_a};
  assign o_b = {pcw_b, ird_b, rw_b, mw_b, mr_b, rs2_b, apc_b, br_b, wb_b, ill_b};

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s %s: got %0h expected %0h (t=%0t)", cur, nm, got, exp, $time);
    end
  endtask

  function automatic ent_t blank(input logic [6:0] op, input logic [2:0] f3, input logic [2:0] cmp);
    ent_t e;
    e.op = op; e.f3 = f3; e.cmp = cmp; e.ir = 1'b1; e.dr = 1'b1; e.st = 3'd0;
    e.pcw = 0; e.ird = 0; e.rw = 0; e.mw = 0; e.mr = 0; e.rs2 = 0; e.apc = 0; e.br = 0;
    e.ill = 0; e.wb = 2'd0;
    return e;
  endfunction

  // Expected per-cycle trace of one instruction, derived from its class.
  task automatic add_instr(input logic [6:0] op, input logic [2:0] f3, input logic [2:0] cmp,
                           input int fwait, input int dwait, input bit fixed, input bit trap_en);
    ent_t e;
    bit r_t, l_t, s_t, b_t, j_t, jr_t, lui_t, au_t, legal, base;
    int nf, nm;
    r_t = (op == 7'b0110011); l_t = (op == 7'b0000011); s_t = (op == 7'b0100011);
    b_t = (op == 7'b1100011); j_t = (op == 7'b1101111); jr_t = (op == 7'b1100111);
    lui_t = (op == 7'b0110111); au_t = (op == 7'b0010111);
    legal = r_t || (op == 7'b0010011) || l_t || s_t || j_t || jr_t || lui_t || au_t ||
            (b_t && f3 != 3'd2 && f3 != 3'd3);
    nf = fixed ? 3 : fwait + 1;
    for (int i = 0; i < nf; i++) begin
      e = blank(op, f3, cmp);
      e.ir = fixed ? 1'b1 : (i == nf - 1);
      e.ird = 1'b1;
      q.push_back(e);
    end
    e = blank(op, f3, cmp);
    e.st = 3'd1;
    if (!legal) begin
      if (trap_en) begin
        q.push_back(e);
        for (int i = 0; i < 3; i++) begin
          e = blank(7'h33, 3'd0, 3'd0);
          e.st = 3'd5; e.ill = 1'b1;
          q.push_back(e);
        end
      end else begin
        e.pcw = 1'b1;
        q.push_back(e);
      end
      return;
    end
    q.push_back(e);
    e = blank(7'h7F, ~f3, cmp);
    e.st = 3'd2; e.rs2 = r_t; e.apc = j_t || au_t;
    if (b_t) begin
      base = (f3[2] == 1'b0) ? cmp[0] : ((f3[1] == 1'b0) ? cmp[1] : cmp[2]);
      e.pcw = 1'b1; e.br = base ^ f3[0];
      q.push_back(e);
      return;
    end
    q.push_back(e);
    if (l_t || s_t) begin
      nm = fixed ? 3 : dwait + 1;
      for (int i = 0; i < nm; i++) begin
        e = blank(7'h7F, ~f3, cmp);
        e.st = 3'd3; e.dr = fixed ? 1'b1 : (i == nm - 1);
        e.mr = l_t; e.mw = s_t; e.pcw = s_t && (i == nm - 1);
        q.push_back(e);
      end
      if (s_t) return;
    end
    e = blank(7'h7F, ~f3, cmp);
    e.st = 3'd4; e.rw = 1'b1; e.pcw = 1'b1; e.br = j_t || jr_t;
    e.wb = l_t ? 2'd1 : ((j_t || jr_t) ? 2'd2 : (lui_t ? 2'd3 : 2'd0));
    q.push_back(e);
  endtask

  // Drives each expected entry's inputs after the rising edge and checks on the falling edge.
  task automatic run_trace(input int limit);
    ent_t e;
    int n = 0;
    while (q.size() > 0 && (limit < 0 || n < limit)) begin
      e = q.pop_front();
      opcode = e.op; func3 = e.f3; compare = e.cmp;
      imem_ready = e.ir; dmem_ready = e.dr;
      @(negedge clk);
      check("state", {29'd0, sel ? st_b : st_a}, {29'd0, e.st});
      check("outputs", {21'd0, sel ? o_b : o_a},
            {21'd0, e.pcw, e.ird, e.rw, e.mw, e.mr, e.rs2, e.apc, e.br, e.wb, e.ill});
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                          input logic [2:0] cmp, input int fwait, input int dwait,
                          input bit fixed, input bit trap_en, input int explen);
    q.delete();
    cur = nm;
    add_instr(op, f3, cmp, fwait, dwait, fixed, trap_en);
    if (explen > 0) check("cycles", q.size(), explen);
    run_trace(-1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {29'd0, st_a}, 32'd0);
    check("rst_illegal", {31'd0, ill_a}, 32'd0);
    check("rst_enables", {29'd0, pcw_a, rw_a, mw_a}, 32'd0);
    rst_n = 1'b1;

    sel = 1'b0;
    do_instr("add",   7'b0110011, 3'd0, 3'b000, 0, 0, 0, 1, 4);
    do_instr("addi",  7'b0010011, 3'd0, 3'b000, 2, 0, 0, 1, 6);
    do_instr("beq",   7'b1100011, 3'd0, 3'b001, 0, 0, 0, 1, 3);
    do_instr("bgeu",  7'b1100011, 3'd7, 3'b100, 0, 0, 0, 1, 3);
    do_instr("blt",   7'b1100011, 3'd4, 3'b010, 0, 0, 0, 1, 3);
    do_instr("bne",   7'b1100011, 3'd1, 3'b001, 0, 0, 0, 1, 3);
    do_instr("lw",    7'b0000011, 3'd2, 3'b000, 0, 3, 0, 1, 8);
    do_instr("lw0",   7'b0000011, 3'd2, 3'b000, 0, 0, 0, 1, 5);
    do_instr("sw",    7'b0100011, 3'd2, 3'b000, 0, 1, 0, 1, 5);
    do_instr("jal",   7'b1101111, 3'd0, 3'b000, 0, 0, 0, 1, 4);
    do_instr("jalr",  7'b1100111, 3'd0, 3'b000, 0, 0, 0, 1, 4);
    do_instr("lui",   7'b0110111, 3'd0, 3'b000, 0, 0, 0, 1, 4);
    do_instr("auipc", 7'b0010111, 3'd0, 3'b000, 0, 0, 0, 1, 4);
    do_instr("trap",  7'h7F,      3'd0, 3'b000, 0, 0, 0, 1, 0);

    cur = "trap_hold";
    check("sticky_state", {29'd0, st_a}, 32'd5);
    check("sticky_illegal", {31'd0, ill_a}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("clr_illegal", {31'd0, ill_a}, 32'd0);
    check("clr_state", {29'd0, st_a}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    q.delete();
    cur = "sw_abort";
    add_instr(7'b0100011, 3'd2, 3'b000, 0, 5, 0, 1);
    run_trace(4);
    dmem_ready = 1'b0;
    #1;
    check("mw_before", {31'd0, mw_a}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mw_after", {31'd0, mw_a}, 32'd0);
    check("state_after", {29'd0, st_a}, 32'd0);
    check("illegal_after", {31'd0, ill_a}, 32'd0);
    check("pcw_after", {31'd0, pcw_a}, 32'd0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_instr("jal_post_rst", 7'b1101111, 3'd0, 3'b000, 0, 0, 0, 1, 4);

    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sel = 1'b1;
    do_instr("b_sw",    7'b0100011, 3'd2, 3'b000, 0, 0, 1, 0, 8);
    do_instr("b_add",   7'b0110011, 3'd0, 3'b000, 0, 0, 1, 0, 6);
    do_instr("b_ill7f", 7'h7F,      3'd0, 3'b000, 0, 0, 1, 0, 4);
    do_instr("b_lw",    7'b0000011, 3'd2, 3'b000, 0, 0, 1, 0, 9);
    do_instr("b_brf3",  7'b1100011, 3'd3, 3'b001, 0, 0, 1, 0, 4);
    do_instr("b_bge",   7'b1100011, 3'd5, 3'b000, 0, 0, 1, 0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
